// File: rtl/onehot_seq_pkg.sv
// Shared types and constants for the one-hot sequencer.
package onehot_seq_pkg;

  typedef logic [3:0] onehot_t;

  localparam onehot_t S0     = 4'b1000;
  localparam onehot_t S1     = 4'b0100;
  localparam onehot_t S2     = 4'b0010;
  localparam onehot_t S3     = 4'b0001;
  localparam onehot_t S_NONE = 4'b0000;

  typedef enum logic {IDLE, RUN} ctrl_e;

  // First code of a pass for the given direction (rev=1 walks 0001->1000).
  function automatic onehot_t first_code(input logic rev);
    return rev ? S3 : S0;
  endfunction

  // Last code of a pass for the given direction.
  function automatic onehot_t last_code(input logic rev);
    return rev ? S0 : S3;
  endfunction

endpackage

// File: rtl/onehot_seq_dwell_cnt.sv
// Loadable down-counter that measures how long each one-hot code is held.
module dwell_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          ck_i,
  input  logic          r_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  // Load takes priority over counting; the counter parks at zero.
  always_ff @(posedge ck_i) begin
    if (r_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_seq.sv
// Four-state one-hot sequencer with programmable dwell, single or continuous runs.
module onehot_seq
  import onehot_seq_pkg::*;
#(
  parameter int unsigned DWELL = 1,
  parameter int unsigned CW    = 8
) (
  input  logic       ck,
  input  logic       r,
  input  logic       start,
  input  logic       dir,
  input  logic       cont,
  input  logic       abort,
  output logic [3:0] state,
  output logic       busy,
  output logic       step,
  output logic       wrap,
  output logic       done
);

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  ctrl_e   ctrl_q, ctrl_d;
  onehot_t state_q, state_d;
  logic    busy_q, busy_d;
  logic    step_q, step_d;
  logic    wrap_q, wrap_d;
  logic    done_q, done_d;
  logic    rev_q, rev_d;
  logic    cnt_load, cnt_en, cnt_zero;

  dwell_cnt #(.CW(CW)) u_dwell (
    .ck_i   (ck),
    .r_i    (r),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (RELOAD),
    .zero_o (cnt_zero)
  );

  // Control/output register bank; reset overrides everything.
  always_ff @(posedge ck) begin
    if (r) begin
      ctrl_q  <= IDLE;
      state_q <= S_NONE;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      rev_q   <= rev_d;
    end
  end

  // Next-state logic: code advance is a rotate in the latched direction.
  always_comb begin
    ctrl_d   = ctrl_q;
    state_d  = state_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    rev_d    = rev_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (ctrl_q)
      IDLE: begin
        state_d = S_NONE;
        busy_d  = 1'b0;
        if (start && !abort) begin
          ctrl_d   = RUN;
          rev_d    = dir;
          state_d  = first_code(dir);
          busy_d   = 1'b1;
          step_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          ctrl_d  = IDLE;
          state_d = S_NONE;
          busy_d  = 1'b0;
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (state_q != last_code(rev_q)) begin
          state_d  = rev_q ? {state_q[2:0], state_q[3]} : {state_q[0], state_q[3:1]};
          step_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (cont) begin
          state_d  = first_code(rev_q);
          step_d   = 1'b1;
          wrap_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          ctrl_d  = IDLE;
          state_d = S_NONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        ctrl_d  = IDLE;
        state_d = S_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign step  = step_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule
